// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Opcode encodings and default data width shared by the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

endpackage

`default_nettype wire

// File: rtl/alu_addsub.sv
// ============================================================================
// Module      : alu_addsub
// Description : Shared adder/subtractor (invert-b plus carry-in) with signed
//               overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] w_b_eff;

  assign w_b_eff = b_i ^ {WIDTH{sub_i}};
  assign sum_o   = a_i + w_b_eff + {{(WIDTH-1){1'b0}}, sub_i};

  // Signed overflow: like-signed operands into the adder producing a result of the other sign.
  assign overflow_o = (a_i[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/alu_16bit.sv
// ============================================================================
// Module      : alu_16bit
// Description : 16-bit integer ALU with combinational result/flags and a
//               status register. Shift/SLTU ops enabled by macro ALU_SHIFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_16bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             overflow_q
);

`ifdef ALU_SHIFT_EN
  localparam int SHAMT_W = $clog2(WIDTH);
`endif

  logic [WIDTH-1:0] w_sum;
  logic             w_sum_ovf;
  logic             w_sub;

  assign w_sub = (alu_control == ALU_SUB);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a_i        (a),
    .b_i        (b),
    .sub_i      (w_sub),
    .sum_o      (w_sum),
    .overflow_o (w_sum_ovf)
  );

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_control)
      ALU_ADD,
      ALU_SUB: begin
        result   = w_sum;
        overflow = w_sum_ovf;
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      // Direct signed compare, so subtraction overflow cannot corrupt SLT.
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SHIFT_EN
      ALU_SLL:  result = a << b[SHAMT_W-1:0];
      ALU_SRL:  result = a >> b[SHAMT_W-1:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[SHAMT_W-1:0]);
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
`endif
      default: ;
    endcase
  end

  assign zero = (result == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      result_q   <= result;
      zero_q     <= zero;
      overflow_q <= overflow;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_16bit.sv
// ============================================================================
// Module      : tb_alu_16bit
// Description : Self-checking bench for alu_16bit (directed + random vectors
//               against an integer-arithmetic reference model).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  alu_control;
  logic [15:0] result;
  logic        zero;
  logic        overflow;
  logic [15:0] result_q;
  logic        zero_q;
  logic        overflow_q;

  int total;
  int bad;

  alu_16bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
    .result_q    (result_q),
    .zero_q      (zero_q),
    .overflow_q  (overflow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: returns {result, zero, overflow} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    int          sx;
    int          sy;
    int          r;
    int          sh;
    logic [15:0] res;
    logic        ovf;
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    sh  = int'(y[3:0]);
    res = 16'h0000;
    ovf = 1'b0;
    r   = 0;
    case (op)
      4'd0: begin r = sx + sy; res = r[15:0]; ovf = (r > 32767) || (r < -32768); end
      4'd1: begin r = sx - sy; res = r[15:0]; ovf = (r > 32767) || (r < -32768); end
      4'd2: res = x & y;
      4'd3: res = x | y;
      4'd4: res = x ^ y;
      4'd5: res = (sx < sy) ? 16'h0001 : 16'h0000;
`ifdef ALU_SHIFT_EN
      4'd6: begin r = int'(x) << sh; res = r[15:0]; end
      4'd7: begin r = int'(x) >> sh; res = r[15:0]; end
      4'd8: begin r = sx >>> sh; res = r[15:0]; end
      4'd9: res = (int'(x) < int'(y)) ? 16'h0001 : 16'h0000;
`endif
      default: res = 16'h0000;
    endcase
    return {res, (res == 16'h0000), ovf};
  endfunction

  task automatic drive(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    alu_control = op;
    a = x;
    b = y;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_control = 4'd0;
    a = 16'h1234;
    b = 16'h5678;
    #12;
    total++;
    if ({result_q, zero_q, overflow_q} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got q=%h z=%b o=%b want q=0000 z=1 o=0", result_q, zero_q, overflow_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Table entries: {op, a, b, result, zero, overflow}
  task automatic test_arith();
    logic [53:0] tbl [7];
    tbl[0] = {4'h0, 16'h1234, 16'h5678, 16'h68AC, 1'b0, 1'b0};
    tbl[1] = {4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    tbl[2] = {4'h0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    tbl[3] = {4'h0, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b0};
    tbl[4] = {4'h1, 16'h5678, 16'h1234, 16'h4444, 1'b0, 1'b0};
    tbl[5] = {4'h1, 16'hABCD, 16'hABCD, 16'h0000, 1'b1, 1'b0};
    tbl[6] = {4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i][53:50], tbl[i][49:34], tbl[i][33:18]);
      total++;
      if ({result, zero, overflow} !== tbl[i][17:0]) begin
        bad++;
        $display("FAIL arith[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b", i,
                 result, zero, overflow, tbl[i][17:2], tbl[i][1], tbl[i][0]);
      end
    end
  endtask

  task automatic test_logic();
    logic [53:0] tbl [4];
    tbl[0] = {4'h2, 16'hFFFF, 16'h5555, 16'h5555, 1'b0, 1'b0};
    tbl[1] = {4'h3, 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0};
    tbl[2] = {4'h4, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    tbl[3] = {4'h4, 16'hFFFF, 16'h5555, 16'hAAAA, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i][53:50], tbl[i][49:34], tbl[i][33:18]);
      total++;
      if ({result, zero, overflow} !== tbl[i][17:0]) begin
        bad++;
        $display("FAIL logic[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b", i,
                 result, zero, overflow, tbl[i][17:2], tbl[i][1], tbl[i][0]);
      end
    end
  endtask

  task automatic test_slt();
    logic [53:0] tbl [3];
    tbl[0] = {4'h5, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0};
    tbl[1] = {4'h5, 16'h0002, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[2] = {4'h5, 16'h8000, 16'h0001, 16'h0001, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(tbl[i][53:50], tbl[i][49:34], tbl[i][33:18]);
      total++;
      if ({result, zero, overflow} !== tbl[i][17:0]) begin
        bad++;
        $display("FAIL slt[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b", i,
                 result, zero, overflow, tbl[i][17:2], tbl[i][1], tbl[i][0]);
      end
    end
  endtask

  task automatic test_undefined();
    logic [53:0] tbl [5];
    tbl[0] = {4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
`ifdef ALU_SHIFT_EN
    tbl[1] = {4'h8, 16'h8000, 16'h0004, 16'hF800, 1'b0, 1'b0};
    tbl[2] = {4'h9, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[3] = {4'h6, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0};
    tbl[4] = {4'h7, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0};
`else
    tbl[1] = {4'h6, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[2] = {4'h7, 16'h8000, 16'h0001, 16'h0000, 1'b1, 1'b0};
    tbl[3] = {4'h8, 16'h8000, 16'h0004, 16'h0000, 1'b1, 1'b0};
    tbl[4] = {4'h9, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0};
`endif
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i][53:50], tbl[i][49:34], tbl[i][33:18]);
      total++;
      if ({result, zero, overflow} !== tbl[i][17:0]) begin
        bad++;
        $display("FAIL undef_or_shift[%0d]: got r=%h z=%b o=%b want r=%h z=%b o=%b", i,
                 result, zero, overflow, tbl[i][17:2], tbl[i][1], tbl[i][0]);
      end
    end
  endtask

  // Random ops each cycle; the registered outputs must lag the comb outputs by one edge.
  task automatic test_random();
    logic [17:0] exp;
    logic [15:0] x;
    logic [15:0] y;
    logic [3:0]  op;
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = 16'($urandom);
      y  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: x = 16'h7FFF;
        1: x = 16'h8000;
        2: y = x;
        3: y = 16'h8000;
        default: ;
      endcase
      exp = model(op, x, y);
      drive(op, x, y);
      total++;
      if ({result, zero, overflow} !== exp) begin
        bad++;
        $display("FAIL random_comb op=%h a=%h b=%h: got r=%h z=%b o=%b want r=%h z=%b o=%b",
                 op, x, y, result, zero, overflow, exp[17:2], exp[1], exp[0]);
      end
      @(posedge clk);
      #1;
      total++;
      if ({result_q, zero_q, overflow_q} !== exp) begin
        bad++;
        $display("FAIL random_reg op=%h a=%h b=%h: got q=%h z=%b o=%b want q=%h z=%b o=%b",
                 op, x, y, result_q, zero_q, overflow_q, exp[17:2], exp[1], exp[0]);
      end
    end
  endtask

  task automatic test_registered();
    drive(4'h0, 16'h7FFF, 16'h0001);
    @(posedge clk);
    #1;
    total++;
    if ({result_q, zero_q, overflow_q} !== {16'h8000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reg_capture: got q=%h z=%b o=%b want q=8000 z=0 o=1", result_q, zero_q, overflow_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({result_q, zero_q, overflow_q} !== {16'h0000, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL async_reset_regs: got q=%h z=%b o=%b want q=0000 z=1 o=0", result_q, zero_q, overflow_q);
    end
    total++;
    if ({result, zero, overflow} !== {16'h8000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset_comb: got r=%h z=%b o=%b want r=8000 z=0 o=1", result, zero, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({result_q, zero_q, overflow_q} !== {16'h8000, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reg_after_release: got q=%h z=%b o=%b want q=8000 z=0 o=1", result_q, zero_q, overflow_q);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_arith();
    test_logic();
    test_slt();
    test_undefined();
    test_random();
    test_registered();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
